// File: rtl/ascensor_pkg.sv
// ascensor_pkg: shared states, button codes and request-mask helpers for the elevator controller.
package ascensor_pkg;
  localparam int N_PISOS = 4;
  localparam int N_PEND = 10;
  localparam logic [3:0] COD_PISO1 = 4'd1;
  localparam logic [3:0] COD_PISO2 = 4'd2;
  localparam logic [3:0] COD_PISO3 = 4'd3;
  localparam logic [3:0] COD_PISO4 = 4'd4;
  localparam logic [3:0] COD_S1 = 4'd5;
  localparam logic [3:0] COD_B2 = 4'd6;
  localparam logic [3:0] COD_S2 = 4'd7;
  localparam logic [3:0] COD_B3 = 4'd8;
  localparam logic [3:0] COD_S3 = 4'd9;
  localparam logic [3:0] COD_B4 = 4'd10;
  typedef enum logic [1:0] {IDLE, SUBE, BAJA, PUERTA} estado_t;
  typedef enum logic {UP, DOWN} dir_t;
  typedef logic [N_PEND-1:0] pend_t;
  function automatic int bit_cabina(input int f);
    return f;
  endfunction
  function automatic int bit_sube(input int f);
    return 4 + 2 * f;
  endfunction
  function automatic int bit_baja(input int f);
    return 3 + 2 * f;
  endfunction
  // Up-calls exist only below the top floor, down-calls only above the ground floor.
  function automatic pend_t mask_parada(input int f, input logic sube, input logic baja);
    pend_t m;
    m = pend_t'(1) << bit_cabina(f);
    if (sube && f < N_PISOS - 1) m = m | (pend_t'(1) << bit_sube(f));
    if (baja && f > 0) m = m | (pend_t'(1) << bit_baja(f));
    return m;
  endfunction
  function automatic pend_t mask_piso(input int f);
    return mask_parada(f, 1'b1, 1'b1);
  endfunction
  function automatic pend_t mask_rango(input int lo, input int hi);
    pend_t m;
    m = '0;
    for (int k = 0; k < N_PISOS; k++)
      if (k >= lo && k <= hi) m = m | mask_piso(k);
    return m;
  endfunction
  function automatic pend_t mask_codigo(input logic [3:0] c);
    return (c >= COD_PISO1 && c <= COD_B4) ? pend_t'(1) << (c - 4'd1) : '0;
  endfunction
  function automatic int piso_codigo(input logic [3:0] c);
    return (c <= COD_PISO4) ? int'(c) - 1 : (int'(c) - int'(COD_S1) + 1) / 2;
  endfunction
endpackage

// File: rtl/temporizador.sv
// temporizador: loadable up-counter flagging when it reaches the selected terminal value.
module temporizador #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cargar,
  input  logic [W-1:0] limite,
  output logic         fin
);
  logic [W-1:0] cuenta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cuenta <= '0;
    else cuenta <= cargar ? '0 : cuenta + W'(1);
  assign fin = cuenta == limite;
endmodule

// File: rtl/control_ascensor.sv
// control_ascensor: latches cabin/hall calls and sequences the car with a collective SCAN policy.
module control_ascensor
  import ascensor_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 100,
  parameter int DOOR_CYCLES = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  boton_pres,
  output logic [1:0]  piso_actual,
  output logic        motor_sube,
  output logic        motor_baja,
  output logic        puerta_abierta,
  output logic [9:0]  pendientes
);
  localparam int MAX_CYC = TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int W = $clog2(MAX_CYC);
  estado_t estado, estado_sig;
  dir_t dir, dir_sig;
  logic [1:0] piso, piso_sig;
  pend_t pend, pend_sig;
  logic [W-1:0] limite;
  logic cargar, fin, reinicio;
  logic req_aqui, req_sobre, req_bajo, para_sube, para_baja, cod_ok;
  assign req_aqui = |(pend & mask_piso(int'(piso)));
  assign req_sobre = |(pend & mask_rango(int'(piso) + 1, N_PISOS - 1));
  assign req_bajo = |(pend & mask_rango(0, int'(piso) - 1));
  // Stop decision evaluated for the floor being reached on this terminal count.
  assign para_sube = |(pend & mask_parada(int'(piso) + 1, 1'b1, 1'b0)) ||
                     !(|(pend & mask_rango(int'(piso) + 2, N_PISOS - 1)));
  assign para_baja = |(pend & mask_parada(int'(piso) - 1, 1'b0, 1'b1)) ||
                     !(|(pend & mask_rango(0, int'(piso) - 2)));
  assign cod_ok = |mask_codigo(boton_pres);
  assign reinicio = estado == PUERTA && cod_ok && piso_codigo(boton_pres) == int'(piso);
  always_comb begin
    estado_sig = estado;
    dir_sig = dir;
    piso_sig = piso;
    case (estado)
      IDLE:
        if (req_aqui) estado_sig = PUERTA;
        else if (dir == UP ? req_sobre : req_bajo) estado_sig = dir == UP ? SUBE : BAJA;
        else if (dir == UP ? req_bajo : req_sobre) begin
          dir_sig = dir == UP ? DOWN : UP;
          estado_sig = dir == UP ? BAJA : SUBE;
        end
      SUBE:
        if (fin) begin
          piso_sig = piso + 2'd1;
          estado_sig = para_sube ? PUERTA : SUBE;
        end
      BAJA:
        if (fin) begin
          piso_sig = piso - 2'd1;
          estado_sig = para_baja ? PUERTA : BAJA;
        end
      PUERTA:
        if (fin && !reinicio) estado_sig = IDLE;
    endcase
  end
  // Clearing on the entry edge also swallows a same-edge press for the arrival floor.
  assign pend_sig = (pend | mask_codigo(boton_pres)) &
                    ~((estado_sig == PUERTA) ? mask_piso(int'(piso_sig)) : pend_t'(0));
  assign cargar = estado == IDLE || estado_sig != estado || fin || reinicio;
  assign limite = estado == PUERTA ? W'(DOOR_CYCLES - 1) : W'(TRAVEL_CYCLES - 1);
  temporizador #(.W(W)) u_tmr (
    .clk(clk),
    .rst_n(rst_n),
    .cargar(cargar),
    .limite(limite),
    .fin(fin)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      estado <= IDLE;
      dir <= UP;
      piso <= '0;
      pend <= '0;
    end else begin
      estado <= estado_sig;
      dir <= dir_sig;
      piso <= piso_sig;
      pend <= pend_sig;
    end
  assign piso_actual = piso;
  assign motor_sube = estado == SUBE;
  assign motor_baja = estado == BAJA;
  assign puerta_abierta = estado == PUERTA;
  assign pendientes = pend;
endmodule

// File: tb/tb_control_ascensor.sv
// tb_control_ascensor: directed scenarios with hand-computed expectations for the elevator controller.
module tb_control_ascensor;
  import ascensor_pkg::*;
  logic clk, rst_n;
  logic [3:0] boton_pres;
  logic [1:0] piso_actual;
  logic motor_sube, motor_baja, puerta_abierta;
  logic [9:0] pendientes;
  int vectors = 0;
  int fails = 0;
  control_ascensor #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .boton_pres(boton_pres),
    .piso_actual(piso_actual),
    .motor_sube(motor_sube),
    .motor_baja(motor_baja),
    .puerta_abierta(puerta_abierta),
    .pendientes(pendientes)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Checks {sube, baja, puerta}, floor and pending mask together.
  task automatic chk_all(input string tag, input logic [2:0] outs, input logic [1:0] p, input logic [9:0] pe);
    chk({tag, ".outs"}, 32'({motor_sube, motor_baja, puerta_abierta}), 32'(outs));
    chk({tag, ".piso"}, 32'(piso_actual), 32'(p));
    chk({tag, ".pend"}, 32'(pendientes), 32'(pe));
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    boton_pres = 4'd0;
    step(2);
    rst_n = 1'b1;
  endtask
  initial begin
    do_reset();
    chk_all("reset", 3'b000, 2'd0, 10'h000);
    chk("reset.dir", 32'(dut.dir), 32'(UP));
    // Cabin call to floor 3 (code 3)
    boton_pres = 4'd3;
    step(1);
    boton_pres = 4'd0;
    chk_all("t1.latch", 3'b000, 2'd0, 10'h004);
    step(1);
    chk_all("t1.move", 3'b100, 2'd0, 10'h004);
    step(4);
    chk_all("t1.f1", 3'b100, 2'd1, 10'h004);
    step(3);
    chk_all("t1.f1end", 3'b100, 2'd1, 10'h004);
    step(1);
    chk_all("t1.arrive", 3'b001, 2'd2, 10'h000);
    step(5);
    chk_all("t1.doorlast", 3'b001, 2'd2, 10'h000);
    step(1);
    chk_all("t1.close", 3'b000, 2'd2, 10'h000);
    chk("t1.state", 32'(dut.estado), 32'(IDLE));
    // Hall call S1 at the current floor
    do_reset();
    boton_pres = 4'd5;
    step(1);
    boton_pres = 4'd0;
    chk_all("t2.latch", 3'b000, 2'd0, 10'h010);
    step(1);
    chk_all("t2.open", 3'b001, 2'd0, 10'h000);
    step(5);
    chk_all("t2.doorlast", 3'b001, 2'd0, 10'h000);
    step(1);
    chk_all("t2.close", 3'b000, 2'd0, 10'h000);
    step(2);
    chk_all("t2.idle", 3'b000, 2'd0, 10'h000);
    // Cabin 4 plus B3: pass floor 2 going up, serve B3 on the way down
    boton_pres = 4'd4;
    step(1);
    boton_pres = 4'd8;
    step(1);
    boton_pres = 4'd0;
    chk_all("t3.start", 3'b100, 2'd0, 10'h088);
    step(8);
    chk_all("t3.pass2", 3'b100, 2'd2, 10'h088);
    step(4);
    chk_all("t3.top", 3'b001, 2'd3, 10'h080);
    step(6);
    chk_all("t3.close", 3'b000, 2'd3, 10'h080);
    step(1);
    chk_all("t3.down", 3'b010, 2'd3, 10'h080);
    chk("t3.dir", 32'(dut.dir), 32'(DOWN));
    step(4);
    chk_all("t3.b3", 3'b001, 2'd2, 10'h000);
    step(6);
    chk_all("t3.idle", 3'b000, 2'd2, 10'h000);
    // Door restart at floor 1
    do_reset();
    boton_pres = 4'd2;
    step(1);
    boton_pres = 4'd0;
    step(5);
    chk_all("t4.arrive", 3'b001, 2'd1, 10'h000);
    step(1);
    boton_pres = 4'd2;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk_all($sformatf("t4.hold%0d", i), 3'b001, 2'd1, 10'h000);
    end
    boton_pres = 4'd0;
    step(5);
    chk_all("t4.doorlast", 3'b001, 2'd1, 10'h000);
    step(1);
    chk_all("t4.close", 3'b000, 2'd1, 10'h000);
    // Asynchronous reset during travel
    do_reset();
    boton_pres = 4'd4;
    step(1);
    boton_pres = 4'd0;
    chk_all("t5.latch", 3'b000, 2'd0, 10'h008);
    step(6);
    chk_all("t5.travel", 3'b100, 2'd1, 10'h008);
    #2 rst_n = 1'b0;
    #1;
    chk_all("t5.async", 3'b000, 2'd0, 10'h000);
    step(2);
    rst_n = 1'b1;
    step(3);
    chk_all("t5.after", 3'b000, 2'd0, 10'h000);
    chk("t5.state", 32'(dut.estado), 32'(IDLE));
    // Ignored codes 11..15 and 0
    for (int c = 11; c <= 16; c++) begin
      boton_pres = 4'(c);
      step(20);
      chk_all($sformatf("t6.code%0d", c % 16), 3'b000, 2'd0, 10'h000);
    end
    boton_pres = 4'd0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/control_ascensor.md
# control_ascensor

Request latch and car sequencer for the 4-floor elevator. Consumes the 4-bit button code from `manejo_entradas`, holds every pending cabin and hall call in a register, and runs a collective (SCAN) state machine that drives the motor up/down outputs, the current-floor register and the door output. It sits between input decoding and the display/motor outputs.

## Interface
- `TRAVEL_CYCLES`, default 100: clock cycles to move one floor; must be at least 2.
- `DOOR_CYCLES`, default 200: clock cycles the door stays open; must be at least 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `boton_pres`  in  4  button code, held while pressed:
  - 0: none.
  - 1–4: cabin button for floors 1–4.
  - 5: S1. 6: B2. 7: S2. 8: B3. 9: S3. 10: B4.
  - 11–15: ignored.
- `piso_actual`  out  2  current floor minus 1 (0..3).
- `motor_sube`  out  1  car moving up.
- `motor_baja`  out  1  car moving down.
- `puerta_abierta`  out  1  door open.
- `pendientes`  out  10  latched requests:
  - Bit i-1 corresponds to code i.
  - Bits 0–3 are cabin calls; bits 4–9 are S1, B2, S2, B3, S3, B4.

## Operation
- **Reset:**
  - State IDLE, `piso_actual` = 0, `pendientes` = 0.
  - `motor_sube`, `motor_baja` and `puerta_abierta` are 0.
  - Direction register `dir` = UP.
- **Latch:** each rising edge with `boton_pres` in 1..10 sets the matching bit. Setting is idempotent, so a held button has no further effect. Exception: a request for the current floor while in PUERTA is not latched; it restarts the door timer instead.
- **Floor request:** floor f is requested if its cabin bit or either hall bit for f is set.
- **IDLE** (all outputs 0 except `piso_actual`). Each cycle, first matching rule wins:
  1. Request at current floor → PUERTA.
  2. Request in `dir` → move in `dir` (SUBE or BAJA).
  3. Request opposite to `dir` → flip `dir`, move that way.
  4. Otherwise stay in IDLE.
- **SUBE** (`motor_sube` = 1):
  - Timer counts 0..TRAVEL_CYCLES-1.
  - At terminal count, `piso_actual` increments.
  - At the new floor g, go to PUERTA if any of: cabin g is pending; up-call at g is pending; no request exists above g. Otherwise stay in SUBE and reload the timer.
- **BAJA:** mirror of SUBE, using down-calls and "no request below".
- **PUERTA** (`puerta_abierta` = 1):
  - On entry and every cycle in this state, clear the cabin bit and both hall bits of the current floor.
  - Timer runs DOOR_CYCLES; at terminal count → IDLE.
- **Invariant:** at most one of `motor_sube`, `motor_baja`, `puerta_abierta` is high. Motor outputs are never high in PUERTA.
- **Floor limits:** `piso_actual` never wraps. SUBE is entered only if a request exists above, BAJA only if one exists below.
- **Reset mid-operation:** `rst_n` low returns every register to its reset value immediately, including clearing `pendientes` and returning to floor 0.

## Timing
- Request latency: a code sampled at edge N is visible in `pendientes` after edge N.
- IDLE decision: uses the registered `pendientes`, so movement or the door starts at edge N+1.
- Move duration: exactly TRAVEL_CYCLES cycles of `motor_sube`/`motor_baja` per floor.
- Floor update: `piso_actual` updates on the same edge as the terminal count.
- Door duration: exactly DOOR_CYCLES cycles when no restart occurs. A restart reloads the timer to 0 on the edge where the request is sampled.
- Door close: the PUERTA → IDLE edge drops `puerta_abierta`. IDLE then takes at least one cycle before any motor output asserts.
- Simultaneous events: on the arrival edge, a press for the arrival floor is absorbed by the PUERTA clearing rule. A press for another floor is latched normally.

## Structure
- Package `ascensor_pkg` holds:
  - State enum: IDLE, SUBE, BAJA, PUERTA.
  - Direction enum.
  - Code constants `COD_PISO1`..`COD_B4` = 1..10.
  - `N_PISOS` = 4.
  - Bit-index functions mapping (floor, cabin/up/down) to a `pendientes` index.
- Sub-module `temporizador`: a loadable counter with `cargar` and `fin` signals. Its width is `$clog2` of the larger of TRAVEL_CYCLES and DOOR_CYCLES. One instance is shared by move and door timing.

## Test plan
Use TRAVEL_CYCLES = 4 and DOOR_CYCLES = 6.
- **Reset then code 3 for 1 cycle:**
  - `pendientes` = 0x004 one edge later.
  - `motor_sube` asserts for 8 cycles; `piso_actual` goes 0→1→2.
  - Door opens for 6 cycles, then `pendientes` = 0, state IDLE.
- **Hall call at current floor:** in IDLE at floor 0, code 5 → PUERTA next edge, bit 4 cleared, no motor activity.
- **Stop on the way, skip opposite call:** at floor 0, latch code 4 and code 8 (B3).
  - Car passes floor 2 without stopping and stops at floor 3.
  - It then reverses to floor 2 for B3. `dir` = DOWN.
- **Door restart:** in PUERTA at floor 1, code 2 held 3 cycles → door stays open 6 cycles after the last press; bit 1 never set.
- **Reset mid-travel:** `rst_n` low during SUBE with `pendientes` = 0x008 → all outputs and `pendientes` return to 0 asynchronously; IDLE at floor 0 after release.
- **Ignored codes:** codes 11–15 and 0 held 20 cycles → `pendientes` stays 0 and the car stays in IDLE.
